// File: rtl/adder_arbiter.sv
// Four-requester arbiter in front of a two-stage split-sum adder; results return tagged with the requester ID.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest) instead of round-robin.
module adder_arbiter #(
    parameter int W    = 16,
    parameter int NREQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*W-1:0]      n1_bus,
    input  logic [NREQ*W-1:0]      n2_bus,
    output logic [NREQ-1:0]        gnt,
    output logic signed [W:0]      sum,
    output logic [1:0]             sum_id,
    output logic                   sum_valid,
    output logic                   busy
);
    localparam int H = W / 2;

    logic [W-1:0] op_a [NREQ];
    logic [W-1:0] op_b [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign op_a[gi] = n1_bus[gi*W +: W];
            assign op_b[gi] = n2_bus[gi*W +: W];
        end
    endgenerate

    logic [1:0] gnt_idx;
    logic       gnt_any;
    logic       issue;

`ifdef ADDER_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_any = 1'b1;
                gnt_idx = 2'(i);
            end
        end
    end
`else
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] rr_cand;

    // Scan offsets high to low so the nearest requester at or after ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        rr_cand = ptr_q;
        for (int i = NREQ - 1; i >= 0; i--) begin
            rr_cand = ptr_q + 2'(i);
            if (req[rr_cand]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (issue) ptr_d = gnt_idx + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 2'd0;
        else     ptr_q <= ptr_d;
    end
`endif

    assign issue = gnt_any & ~rst;

    always_comb begin
        gnt = '0;
        if (issue) gnt[gnt_idx] = 1'b1;
    end

    // Stage 1: low half sum with its carry, high halves parked for stage 2.
    logic [W-1:0] sel_a, sel_b;
    logic [H:0]   lo_d, lo_q;
    logic [H-1:0] hi_a_q, hi_b_q;
    logic [1:0]   id1_q;
    logic         v1_q;

    assign sel_a = op_a[gnt_idx];
    assign sel_b = op_b[gnt_idx];
    assign lo_d  = {1'b0, sel_a[H-1:0]} + {1'b0, sel_b[H-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q   <= '0;
            hi_a_q <= '0;
            hi_b_q <= '0;
            id1_q  <= 2'd0;
            v1_q   <= 1'b0;
        end else begin
            v1_q <= issue;
            if (issue) begin
                lo_q   <= lo_d;
                hi_a_q <= sel_a[W-1:H];
                hi_b_q <= sel_b[W-1:H];
                id1_q  <= gnt_idx;
            end
        end
    end

    // Stage 2: signed high halves plus the low carry; H+1 bits cannot overflow.
    logic [H:0] hi_d;
    logic [W:0] sum_d, sum_q;
    logic [1:0] sum_id_q;
    logic       sum_valid_q;

    assign hi_d  = {hi_a_q[H-1], hi_a_q} + {hi_b_q[H-1], hi_b_q} + {{H{1'b0}}, lo_q[H]};
    assign sum_d = {hi_d, lo_q[H-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            sum_id_q    <= 2'd0;
            sum_valid_q <= 1'b0;
        end else begin
            sum_valid_q <= v1_q;
            if (v1_q) begin
                sum_q    <= sum_d;
                sum_id_q <= id1_q;
            end
        end
    end

    assign sum       = sum_q;
    assign sum_id    = sum_id_q;
    assign sum_valid = sum_valid_q;
    assign busy      = v1_q | issue | sum_valid_q;

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one two-stage pipelined split-sum adder (low byte in stage 1, high byte plus carry in stage 2) among 4 requesters.
- Round-robin arbitration, one operation issued per cycle.
- Each operation is tagged with its requester ID, and the result is returned with the tag and a one-cycle valid strobe.
- Sits between lab client blocks and the shared arithmetic resource. The block contains its own copy of the pipelined adder datapath.

Parameters:
- W, 16, operand width in bits; must be even and >= 4. The split point is W/2.
- NREQ, 4, number of requesters; fixed at 4. IDs are 2 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- req  input  4  request per requester; level, held until granted
- n1_bus  input  4*W  operand A per requester; requester i occupies bits [i*W +: W], signed
- n2_bus  input  4*W  operand B per requester, same packing, signed
- gnt  output  4  one-hot grant, combinational; operands of the granted requester are captured at this clock edge
- sum  output  W+1  registered signed sum
- sum_id  output  2  requester ID of the current sum
- sum_valid  output  1  one-cycle strobe; sum/sum_id are valid
- busy  output  1  high while any operation is in flight in stage 1 or stage 2

Behaviour:
- Reset: while rst is high at an edge:
  - ptr <= 0; stage-1/2 valid bits <= 0; sum <= 0; sum_id <= 0; sum_valid <= 0.
  - gnt is forced to 0 combinationally while rst = 1.
  - In-flight operations are discarded, never emitted.
- Arbitration (round-robin, combinational):
  - Search req starting at index ptr, wrapping 3 -> 0. The first set bit gets gnt.
  - req = 0 gives gnt = 0.
  - On any grant, ptr <= (granted index + 1) mod 4.
  - A requester sees gnt for exactly one cycle per accepted operation. To issue back-to-back it keeps req high; it gets its next grant after the other active requesters have been served.
- Stage 1, at an edge with a grant:
  - lo <= n1[W/2-1:0] + n2[W/2-1:0] as an unsigned (W/2+1)-bit sum.
  - hi_a <= n1[W-1:W/2] (signed), hi_b <= n2[W-1:W/2] (signed).
  - id1 <= granted index; v1 <= 1.
  - With no grant, v1 <= 0.
- Stage 2, next edge:
  - hi = sign-extended hi_a + hi_b + lo[W/2], as a signed (W/2+1)-bit value.
  - sum <= {hi, lo[W/2-1:0]}; sum_id <= id1; sum_valid <= v1.
- Latency:
  - Grant at edge k gives sum_valid high in the cycle after edge k+2 (2-cycle latency).
  - Throughput 1 operation per cycle; no backpressure.
- When sum_valid = 0, sum and sum_id hold their last values.
- Arithmetic: exact W+1-bit signed sum, no overflow possible. Examples: -32768 + -32768 = -65536; 32767 + 32767 = 65534.
- busy = v1 | (a grant is issued this cycle) | an op pending in stage 2.
- Simultaneous events:
  - A request rising in the same cycle ptr points to it is granted that cycle.
  - req dropping without a grant is legal; nothing is issued.

Optional Feature:
- Macro ADDER_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, req[0] highest through req[3] lowest. ptr register is removed.
- Undefined: round-robin as above.
- Latency, datapath and reset behaviour are identical in both builds.

Test Plan:
- Reset then idle: rst high 2 cycles, req=0 -> gnt=0, sum=0, sum_id=0, sum_valid=0, busy=0 for 10 cycles.
- Single request: req=0001, n1[0]=300, n2[0]=-45 -> gnt=0001 for one cycle; 2 cycles later sum=255, sum_id=0, sum_valid pulse 1 cycle.
- Carry and extremes, back to back from requester 2:
  - 0x00FF+0x0001 = 256, then -32768+-32768 = -65536, then 32767+32767 = 65534.
  - Results appear on consecutive cycles in order, sum_id=2.
- Round-robin fairness: req=1111 held 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3; sum_id sequence matches, with 2-cycle lag. With ADDER_ARB_FIXED_PRIO_EN, gnt=0001 every cycle.
- Reset mid-operation: grant at cycle k, rst high at edge k+1 -> no sum_valid pulse ever emitted for that op; sum=0 after reset; ptr=0.
- Wrap of ptr: only req[3] then req[0] active -> after grant to 3, ptr=0, next grant to 0 in the following cycle.
